// File: rtl/bitstream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_loader_if
// Purpose  : Fabric-side configuration word stream with ready/valid handshake
//            and the fabric's completion report.
// Revision : 1.0 - initial release
// ============================================================================
interface bitstream_loader_if #(
    parameter int WORD_W = 77
);
    logic [WORD_W-1:0] bit_o;
    logic              bit_v_o;
    logic              bit_r_i;
    logic              done_i;

    modport master (
        output bit_o,
        output bit_v_o,
        input  bit_r_i,
        input  done_i
    );

    modport slave (
        input  bit_o,
        input  bit_v_o,
        output bit_r_i,
        output done_i
    );
endinterface
`default_nettype wire

// File: rtl/bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_loader
// Purpose  : Streams a stored bitstream to the fabric in bursts of GROUP words
//            separated by GAP_CYCLES idle cycles, then waits for done_i.
//            Optional macro BITSTREAM_LOADER_TIMEOUT_EN adds a done_i timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bitstream_loader #(
    parameter int WORD_W         = 77,
    parameter int NUM_WORDS      = 16,
    parameter int GROUP          = 4,
    parameter int GAP_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_WORDS)-1:0] wr_addr,
    input  logic [WORD_W-1:0]            wr_data,
    input  logic                         start_i,
    bitstream_loader_if.master           fab,
    output logic                         busy_o,
    output logic                         cfg_done_o,
    output logic                         err_o
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SEND      = 3'd1;
    localparam logic [2:0] c_GAP       = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_FINISH    = 3'd4;
    localparam logic [2:0] c_ERROR     = 3'd5;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [GRP_W-1:0] c_GRP_LAST = GRP_W'(GROUP - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [WORD_W-1:0] r_mem [NUM_WORDS];

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_index;
    logic [GRP_W-1:0]  r_grp;
    logic [GAP_W-1:0]  r_gap;
    logic [WORD_W-1:0] r_bit;
    logic              r_bit_v;
    logic              r_cfg_done;

    logic              w_xfer;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_last;
    logic              w_grp_end;

`ifdef BITSTREAM_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic              r_err;
    logic [TO_W-1:0]   r_to;
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign w_xfer     = r_bit_v & fab.bit_r_i;
    assign w_next_idx = r_index + 1'b1;
    assign w_last     = (r_index == c_LAST_IDX);
    assign w_grp_end  = (r_grp == c_GRP_LAST);

    assign busy_o      = (r_state == c_SEND) || (r_state == c_GAP) || (r_state == c_WAIT_DONE);
    assign cfg_done_o  = r_cfg_done;
    assign fab.bit_o   = r_bit;
    assign fab.bit_v_o = r_bit_v;

    // Host writes are frozen while streaming so the presented word never changes under the fabric.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_o) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_index    <= '0;
            r_grp      <= '0;
            r_gap      <= '0;
            r_bit      <= '0;
            r_bit_v    <= 1'b0;
            r_cfg_done <= 1'b0;
`ifdef BITSTREAM_LOADER_TIMEOUT_EN
            r_err      <= 1'b0;
            r_to       <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_FINISH, c_ERROR: begin
                    if (start_i) begin
                        r_state    <= c_SEND;
                        r_index    <= '0;
                        r_grp      <= '0;
                        r_bit      <= r_mem[0];
                        r_bit_v    <= 1'b1;
                        r_cfg_done <= 1'b0;
`ifdef BITSTREAM_LOADER_TIMEOUT_EN
                        r_err      <= 1'b0;
`endif
                    end
                end
                c_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= c_WAIT_DONE;
                            r_bit   <= '0;
                            r_bit_v <= 1'b0;
`ifdef BITSTREAM_LOADER_TIMEOUT_EN
                            r_to    <= '0;
`endif
                        end else if (w_grp_end && (GAP_CYCLES > 0)) begin
                            r_state <= c_GAP;
                            r_gap   <= '0;
                            r_grp   <= '0;
                            r_index <= w_next_idx;
                            r_bit   <= '0;
                            r_bit_v <= 1'b0;
                        end else begin
                            // Next word is registered now so a back-to-back transfer follows immediately.
                            r_index <= w_next_idx;
                            r_grp   <= w_grp_end ? '0 : r_grp + 1'b1;
                            r_bit   <= r_mem[w_next_idx];
                        end
                    end
                end
                c_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= c_SEND;
                        r_bit   <= r_mem[r_index];
                        r_bit_v <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                c_WAIT_DONE: begin
                    if (fab.done_i) begin
                        r_state    <= c_FINISH;
                        r_cfg_done <= 1'b1;
                    end
`ifdef BITSTREAM_LOADER_TIMEOUT_EN
                    else if (r_to == c_TO_LAST) begin
                        r_state <= c_ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitstream_loader
// Purpose  : Randomized bench for bitstream_loader with a phase-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitstream_loader;

    localparam int WORD_W         = 77;
    localparam int NUM_WORDS      = 16;
    localparam int GROUP          = 4;
    localparam int GAP_CYCLES     = 5;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int AW             = $clog2(NUM_WORDS);

    localparam int M_OFF  = 0;
    localparam int M_SEND = 1;
    localparam int M_GAP  = 2;
    localparam int M_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [WORD_W-1:0] wr_data = '0;
    logic              start_i = 1'b0;
    logic              busy_o;
    logic              cfg_done_o;
    logic              err_o;

    bitstream_loader_if #(.WORD_W(WORD_W)) fab ();

    bitstream_loader #(
        .WORD_W        (WORD_W),
        .NUM_WORDS     (NUM_WORDS),
        .GROUP         (GROUP),
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start_i   (start_i),
        .fab       (fab),
        .busy_o    (busy_o),
        .cfg_done_o(cfg_done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;
    bit rand_rdy = 1'b0;

    logic [WORD_W-1:0] w [NUM_WORDS];
    logic [WORD_W-1:0] rxq [$];
    int                rxc [$];

    // Model: tracks which phase of the stream we are in and how many words were sent.
    logic [WORD_W-1:0] m_mem [NUM_WORDS];
    int m_mode, m_idx, m_gap, m_wait;
    bit m_done, m_err;

    task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_OFF;
            m_idx  <= 0;
            m_gap  <= 0;
            m_wait <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            if (m_mode == M_OFF && wr_en) m_mem[wr_addr] <= wr_data;
            case (m_mode)
                M_OFF: begin
                    if (start_i) begin
                        m_mode <= M_SEND;
                        m_idx  <= 0;
                        m_done <= 1'b0;
                        m_err  <= 1'b0;
                    end
                end
                M_SEND: begin
                    if (fab.bit_r_i) begin
                        if (m_idx == NUM_WORDS - 1) begin
                            m_mode <= M_WAIT;
                            m_wait <= 0;
                        end else begin
                            m_idx <= m_idx + 1;
                            if ((m_idx + 1) % GROUP == 0 && GAP_CYCLES > 0) begin
                                m_mode <= M_GAP;
                                m_gap  <= GAP_CYCLES;
                            end
                        end
                    end
                end
                M_GAP: begin
                    m_gap <= m_gap - 1;
                    if (m_gap == 1) m_mode <= M_SEND;
                end
                M_WAIT: begin
                    if (fab.done_i) begin
                        m_mode <= M_OFF;
                        m_done <= 1'b1;
                    end
`ifdef BITSTREAM_LOADER_TIMEOUT_EN
                    else if (m_wait + 1 == TIMEOUT_CYCLES) begin
                        m_mode <= M_OFF;
                        m_err  <= 1'b1;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
`endif
                end
                default: m_mode <= M_OFF;
            endcase
        end
    end

    logic              exp_v;
    logic [WORD_W-1:0] exp_bit;
    bit                prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_bit;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_v   = (m_mode == M_SEND);
            exp_bit = exp_v ? m_mem[m_idx] : '0;
            chk("bit_v_o", WORD_W'(fab.bit_v_o), WORD_W'(exp_v));
            chk("bit_o", fab.bit_o, exp_bit);
            chk("busy_o", WORD_W'(busy_o), WORD_W'(m_mode != M_OFF));
            chk("cfg_done_o", WORD_W'(cfg_done_o), WORD_W'(m_done));
            chk("err_o", WORD_W'(err_o), WORD_W'(m_err));
            if (prev_stall && fab.bit_v_o) chk("stall_hold", fab.bit_o, prev_bit);
            if (fab.bit_v_o && fab.bit_r_i) begin
                rxq.push_back(fab.bit_o);
                rxc.push_back(cyc);
            end
            prev_stall = rst && fab.bit_v_o && !fab.bit_r_i;
            prev_bit   = fab.bit_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_rdy) fab.bit_r_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (rxq.size() < n) begin
            errors++;
            $display("FAIL wait_rx: got %0d words expected %0d", rxq.size(), n);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic give_done();
        done_pulse();
        chk("done_flag", WORD_W'(cfg_done_o), WORD_W'(1));
        chk("done_idle", WORD_W'(busy_o), WORD_W'(0));
    endtask

    task automatic done_pulse();
        fab.done_i = 1'b1;
        tick();
        fab.done_i = 1'b0;
    endtask

    task automatic check_stream(input string nm);
        chk({nm, "_count"}, WORD_W'(rxq.size()), WORD_W'(NUM_WORDS));
        if (rxq.size() == NUM_WORDS) begin
            for (int i = 0; i < NUM_WORDS; i++) chk({nm, "_word"}, rxq[i], w[i]);
        end
    endtask

    int exp_off [NUM_WORDS] = '{0, 1, 2, 3, 9, 10, 11, 12, 18, 19, 20, 21, 27, 28, 29, 30};

    initial begin
        logic [95:0] t;
        fab.bit_r_i = 1'b0;
        fab.done_i  = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("reset_bit_v", WORD_W'(fab.bit_v_o), '0);
        chk("reset_bit", fab.bit_o, '0);
        chk("reset_busy", WORD_W'(busy_o), '0);
        chk("reset_cfg_done", WORD_W'(cfg_done_o), '0);
        chk("reset_err", WORD_W'(err_o), '0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NUM_WORDS; i++) begin
            t = {$urandom, $urandom, $urandom};
            w[i] = t[WORD_W-1:0];
            w[i][7:0] = 8'(i);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = w[i];
            tick();
        end
        wr_en = 1'b0;
        tick();

        // Constant ready: fixed burst/gap timing.
        rxq.delete(); rxc.delete();
        fab.bit_r_i = 1'b1;
        pulse_start();
        wait_rx(NUM_WORDS, 200);
        give_done();
        check_stream("burst");
        if (rxc.size() == NUM_WORDS) begin
            for (int i = 0; i < NUM_WORDS; i++) chk("burst_timing", WORD_W'(rxc[i] - rxc[0]), WORD_W'(exp_off[i]));
        end
        tick();

        // Random ready with 50% duty.
        rxq.delete(); rxc.delete();
        rand_rdy = 1'b1;
        pulse_start();
        wait_rx(NUM_WORDS, 600);
        rand_rdy = 1'b0;
        fab.bit_r_i = 1'b1;
        give_done();
        check_stream("random");
        tick();

        // Asynchronous reset while word 6 is presented.
        rxq.delete(); rxc.delete();
        pulse_start();
        wait_rx(6, 100);
        chk("pre_reset_valid", WORD_W'(fab.bit_v_o), WORD_W'(1));
        chk("pre_reset_word6", fab.bit_o, w[6]);
        #2;
        rst = 1'b0;
        #1;
        chk("async_bit_v", WORD_W'(fab.bit_v_o), '0);
        chk("async_bit", fab.bit_o, '0);
        chk("async_busy", WORD_W'(busy_o), '0);
        chk("async_cfg_done", WORD_W'(cfg_done_o), '0);
        chk("async_err", WORD_W'(err_o), '0);
        tick();
        rst = 1'b1;
        tick();
        rxq.delete(); rxc.delete();
        pulse_start();
        wait_rx(1, 20);
        if (rxq.size() > 0) chk("restart_first", rxq[0], w[0]);
        wait_rx(NUM_WORDS, 200);
        give_done();
        check_stream("restart");
        tick();

        // Write and start while busy must not disturb the stream.
        rxq.delete(); rxc.delete();
        pulse_start();
        wait_rx(2, 50);
        wr_en   = 1'b1;
        wr_addr = AW'(3);
        wr_data = ~w[3];
        start_i = 1'b1;
        tick();
        wr_en   = 1'b0;
        start_i = 1'b0;
        wait_rx(NUM_WORDS, 200);
        give_done();
        check_stream("busy_wr");
        if (rxq.size() > 3) chk("mem3_kept", rxq[3], w[3]);
        tick();

`ifdef BITSTREAM_LOADER_TIMEOUT_EN
        rxq.delete(); rxc.delete();
        pulse_start();
        wait_rx(NUM_WORDS, 200);
        repeat (TIMEOUT_CYCLES - 1) tick();
        chk("to_err_before", WORD_W'(err_o), '0);
        chk("to_busy_before", WORD_W'(busy_o), WORD_W'(1));
        tick();
        chk("to_err_after", WORD_W'(err_o), WORD_W'(1));
        chk("to_busy_after", WORD_W'(busy_o), '0);
        chk("to_cfg_done", WORD_W'(cfg_done_o), '0);
        tick();
        rxq.delete(); rxc.delete();
        pulse_start();
        chk("to_err_cleared", WORD_W'(err_o), '0);
        wait_rx(NUM_WORDS, 200);
        repeat (TIMEOUT_CYCLES - 1) tick();
        done_pulse();
        chk("last_cycle_done", WORD_W'(cfg_done_o), WORD_W'(1));
        chk("last_cycle_err", WORD_W'(err_o), '0);
`else
        rxq.delete(); rxc.delete();
        pulse_start();
        wait_rx(NUM_WORDS, 200);
        repeat (2000) tick();
        chk("long_wait_err", WORD_W'(err_o), '0);
        chk("long_wait_busy", WORD_W'(busy_o), WORD_W'(1));
        chk("long_wait_valid", WORD_W'(fab.bit_v_o), '0);
        chk("long_wait_cfg_done", WORD_W'(cfg_done_o), '0);
        give_done();
`endif
        tick();
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
